// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the dmem arbiter: owner encoding,
// round-robin pointer values and default widths.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_PROC  = 2'd1,
        OWN_VGA   = 2'd2,
        OWN_SERVO = 2'd3
    } owner_t;

    localparam logic RR_VGA   = 1'b0;
    localparam logic RR_SERVO = 1'b1;

    localparam int DEF_ADDR_W       = 12;
    localparam int DEF_DATA_W       = 32;
    localparam int DEF_STARVE_LIMIT = 64;

endpackage

// File: rtl/dmem_arb_wait_ctr.sv
// Saturating wait counter for one arbitrated client; limit_hit is high
// while the count sits at STARVE_LIMIT.
module dmem_arb_wait_ctr
    import dmem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic clock,
    input  logic reset,
    input  logic req,
    input  logic gnt,
    output logic limit_hit
);

    localparam int CW = $clog2(STARVE_LIMIT) + 1;
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [CW-1:0] count;

    always_ff @(posedge clock) begin
        if (reset || !req || gnt) begin
            count <= '0;
        end else if (count != LIMIT) begin
            count <= count + 1'b1;
        end
    end

    assign limit_hit = (count == LIMIT);

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port dmem arbiter: processor has absolute priority, VGA writes and
// servo reads share the remaining cycles round-robin with zero grant latency.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              proc_en,
    input  logic [ADDR_W-1:0] proc_addr,
    input  logic [DATA_W-1:0] proc_data,
    input  logic              proc_wren,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    input  logic [DATA_W-1:0] vga_wdata,
    output logic              vga_gnt,
    input  logic              servo_req,
    input  logic [ADDR_W-1:0] servo_addr,
    output logic              servo_gnt,
    output logic              servo_rvalid,
    output logic [DATA_W-1:0] servo_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_q,
    output logic              starve
);

    owner_t            owner;
    logic              rr_last;
    logic              pend_p1;
    logic [DATA_W-1:0] rdata_p1;
    logic              vga_hit;
    logic              servo_hit;
    logic              starve_q;

    always_comb begin
        owner = OWN_NONE;
        if (reset) begin
            owner = OWN_NONE;
        end else if (proc_en) begin
            owner = OWN_PROC;
        end else if (vga_req && servo_req) begin
            owner = (rr_last == RR_VGA) ? OWN_SERVO : OWN_VGA;
        end else if (vga_req) begin
            owner = OWN_VGA;
        end else if (servo_req) begin
            owner = OWN_SERVO;
        end
    end

    always_comb begin
        mem_addr = '0;
        mem_data = '0;
        mem_wren = 1'b0;
        case (owner)
            OWN_PROC: begin
                mem_addr = proc_addr;
                mem_data = proc_data;
                mem_wren = proc_wren;
            end
            OWN_VGA: begin
                mem_addr = vga_addr;
                mem_data = vga_wdata;
                mem_wren = 1'b1;
            end
            OWN_SERVO: begin
                mem_addr = servo_addr;
            end
            default: begin
            end
        endcase
    end

    assign vga_gnt   = (owner == OWN_VGA);
    assign servo_gnt = (owner == OWN_SERVO);

    // Pointer moves only on client grants; processor cycles leave it alone.
    always_ff @(posedge clock) begin
        if (reset) begin
            rr_last <= RR_SERVO;
        end else if (owner == OWN_VGA) begin
            rr_last <= RR_VGA;
        end else if (owner == OWN_SERVO) begin
            rr_last <= RR_SERVO;
        end
    end

    // Stage p1: dmem clocks on the falling edge, so mem_q already holds the
    // servo word at the rising edge that ends the grant cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            pend_p1  <= 1'b0;
            rdata_p1 <= '0;
        end else begin
            pend_p1 <= (owner == OWN_SERVO);
            if (owner == OWN_SERVO) begin
                rdata_p1 <= mem_q;
            end
        end
    end

    assign servo_rvalid = pend_p1 & ~reset;
    assign servo_rdata  = rdata_p1;

    dmem_arb_wait_ctr #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_vga_wait (
        .clock    (clock),
        .reset    (reset),
        .req      (vga_req),
        .gnt      (vga_gnt),
        .limit_hit(vga_hit)
    );

    dmem_arb_wait_ctr #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_servo_wait (
        .clock    (clock),
        .reset    (reset),
        .req      (servo_req),
        .gnt      (servo_gnt),
        .limit_hit(servo_hit)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            starve_q <= 1'b0;
        end else begin
            starve_q <= starve_q | vga_hit | servo_hit;
        end
    end

    assign starve = starve_q | vga_hit | servo_hit;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: falling-edge dmem model, grant vector table,
// servo read scoreboard and hand-written reset/starvation sequences.
module tb_dmem_arbiter;

    localparam int ADDR_W       = 12;
    localparam int DATA_W       = 32;
    localparam int STARVE_LIMIT = 64;

    logic              clock = 1'b0;
    logic              reset;
    logic              proc_en;
    logic [ADDR_W-1:0] proc_addr;
    logic [DATA_W-1:0] proc_data;
    logic              proc_wren;
    logic              vga_req;
    logic [ADDR_W-1:0] vga_addr;
    logic [DATA_W-1:0] vga_wdata;
    logic              vga_gnt;
    logic              servo_req;
    logic [ADDR_W-1:0] servo_addr;
    logic              servo_gnt;
    logic              servo_rvalid;
    logic [DATA_W-1:0] servo_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              mem_wren;
    logic [DATA_W-1:0] mem_q;
    logic              starve;

    always #5 clock = ~clock;

    dmem_arbiter #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .proc_en     (proc_en),
        .proc_addr   (proc_addr),
        .proc_data   (proc_data),
        .proc_wren   (proc_wren),
        .vga_req     (vga_req),
        .vga_addr    (vga_addr),
        .vga_wdata   (vga_wdata),
        .vga_gnt     (vga_gnt),
        .servo_req   (servo_req),
        .servo_addr  (servo_addr),
        .servo_gnt   (servo_gnt),
        .servo_rvalid(servo_rvalid),
        .servo_rdata (servo_rdata),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .mem_wren    (mem_wren),
        .mem_q       (mem_q),
        .starve      (starve)
    );

    // dmem behaves like the real block: registered on the falling edge.
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    always @(negedge clock) begin
        if (mem_wren) mem[mem_addr] <= mem_data;
        mem_q <= mem[mem_addr];
    end

    logic [DATA_W-1:0] shadow [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] sb [$];
    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Ends the current cycle: drains the scoreboard, then moves to posedge+1.
    task automatic tick();
        logic [DATA_W-1:0] exp;
        if (servo_rvalid) begin
            if (sb.size() == 0) begin
                chk1("rvalid_unexpected", servo_rvalid, 1'b0);
            end else begin
                exp = sb.pop_front();
                chk32("servo_rdata_sb", servo_rdata, exp);
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        proc_en   = 1'b0;
        proc_wren = 1'b0;
        vga_req   = 1'b0;
        servo_req = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        @(posedge clock);
        #1;
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    // Packed vector: {pe, pw, vr, sr, exp_vga_gnt, exp_servo_gnt, exp_wren, exp_addr}
    typedef struct packed {
        logic              pe;
        logic              pw;
        logic              vr;
        logic              sr;
        logic              vg;
        logic              sg;
        logic              ew;
        logic [ADDR_W-1:0] ea;
    } vec_t;

    localparam int NV = 14;
    vec_t vec [NV];
    logic prev_sg;

    initial begin
        vec[0]  = {7'b0000_000, 12'h000};
        vec[1]  = {7'b0010_101, 12'h030};
        vec[2]  = {7'b0001_010, 12'h030};
        vec[3]  = {7'b0011_101, 12'h030};
        vec[4]  = {7'b0011_010, 12'h030};
        vec[5]  = {7'b0011_101, 12'h030};
        vec[6]  = {7'b1111_001, 12'h020};
        vec[7]  = {7'b1011_000, 12'h020};
        vec[8]  = {7'b0011_010, 12'h030};
        vec[9]  = {7'b0010_101, 12'h030};
        vec[10] = {7'b0010_101, 12'h030};
        vec[11] = {7'b0011_010, 12'h030};
        vec[12] = {7'b0001_010, 12'h030};
        vec[13] = {7'b0000_000, 12'h000};

        idle_inputs();
        reset      = 1'b1;
        proc_addr  = '0;
        proc_data  = '0;
        vga_addr   = '0;
        vga_wdata  = '0;
        servo_addr = '0;
        @(posedge clock);
        #1;

        // Reset: a waiting VGA request must not reach dmem.
        vga_req   = 1'b1;
        vga_addr  = 12'h010;
        vga_wdata = 32'h1234_5678;
        #1;
        chk1("rst_mem_wren", mem_wren, 1'b0);
        chk1("rst_vga_gnt", vga_gnt, 1'b0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        idle_inputs();
        #1;
        chk1("rst_rvalid", servo_rvalid, 1'b0);
        chk32("rst_rdata", servo_rdata, 32'h0);
        chk1("rst_starve", starve, 1'b0);
        chk32("rst_mem_addr", 32'(mem_addr), 32'h0);
        tick();

        // VGA write then servo readback.
        vga_req   = 1'b1;
        vga_addr  = 12'h010;
        vga_wdata = 32'hDEAD_BEEF;
        #1;
        chk1("a_vga_gnt", vga_gnt, 1'b1);
        chk1("a_mem_wren", mem_wren, 1'b1);
        chk32("a_mem_addr", 32'(mem_addr), 32'h010);
        chk32("a_mem_data", mem_data, 32'hDEAD_BEEF);
        shadow[12'h010] = 32'hDEAD_BEEF;
        tick();
        vga_req    = 1'b0;
        servo_req  = 1'b1;
        servo_addr = 12'h010;
        #1;
        chk1("a_servo_gnt", servo_gnt, 1'b1);
        chk1("a_servo_wren", mem_wren, 1'b0);
        chk32("a_servo_mem_data", mem_data, 32'h0);
        chk1("a_rvalid_early", servo_rvalid, 1'b0);
        sb.push_back(shadow[12'h010]);
        tick();
        servo_req = 1'b0;
        #1;
        chk1("a_rvalid", servo_rvalid, 1'b1);
        chk32("a_rdata", servo_rdata, 32'hDEAD_BEEF);
        tick();
        #1;
        chk1("a_rvalid_pulse", servo_rvalid, 1'b0);
        chk32("a_rdata_hold", servo_rdata, 32'hDEAD_BEEF);
        tick();

        // Processor store preempts both clients; the pointer must not move.
        proc_en    = 1'b1;
        proc_wren  = 1'b1;
        proc_addr  = 12'h020;
        proc_data  = 32'h5;
        vga_req    = 1'b1;
        vga_addr   = 12'h030;
        vga_wdata  = 32'h1111_2222;
        servo_req  = 1'b1;
        servo_addr = 12'h020;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk32("e_mem_addr", 32'(mem_addr), 32'h020);
            chk32("e_mem_data", mem_data, 32'h5);
            chk1("e_mem_wren", mem_wren, 1'b1);
            chk1("e_vga_gnt", vga_gnt, 1'b0);
            chk1("e_servo_gnt", servo_gnt, 1'b0);
            tick();
        end
        shadow[12'h020] = 32'h5;
        proc_en   = 1'b0;
        proc_wren = 1'b0;
        #1;
        chk1("e_vga_first", vga_gnt, 1'b1);
        chk1("e_servo_wait", servo_gnt, 1'b0);
        shadow[12'h030] = 32'h1111_2222;
        tick();
        vga_req = 1'b0;
        #1;
        chk1("e_servo_next", servo_gnt, 1'b1);
        sb.push_back(shadow[12'h020]);
        tick();
        servo_req = 1'b0;
        #1;
        chk1("e_rvalid", servo_rvalid, 1'b1);
        chk32("e_rdata", servo_rdata, 32'h5);
        tick();

        // Reset right after a servo grant cancels the read.
        servo_req  = 1'b1;
        servo_addr = 12'h010;
        #1;
        chk1("c_servo_gnt", servo_gnt, 1'b1);
        tick();
        servo_req = 1'b0;
        reset     = 1'b1;
        #1;
        chk1("c_rvalid_in_reset", servo_rvalid, 1'b0);
        tick();
        reset = 1'b0;
        #1;
        chk1("c_rvalid_after", servo_rvalid, 1'b0);
        chk32("c_rdata_after", servo_rdata, 32'h0);
        tick();

        // Grant table from a fresh reset (VGA wins the first tie).
        do_reset();
        proc_addr  = 12'h020;
        proc_data  = 32'h77;
        vga_addr   = 12'h030;
        servo_addr = 12'h030;
        prev_sg    = 1'b0;
        for (int i = 0; i < NV; i++) begin
            proc_en   = vec[i].pe;
            proc_wren = vec[i].pw;
            vga_req   = vec[i].vr;
            servo_req = vec[i].sr;
            vga_wdata = 32'hA000_0000 + 32'(i);
            #1;
            chk1($sformatf("vec%0d_vga_gnt", i), vga_gnt, vec[i].vg);
            chk1($sformatf("vec%0d_servo_gnt", i), servo_gnt, vec[i].sg);
            chk1($sformatf("vec%0d_mem_wren", i), mem_wren, vec[i].ew);
            chk32($sformatf("vec%0d_mem_addr", i), 32'(mem_addr), 32'(vec[i].ea));
            chk1($sformatf("vec%0d_rvalid", i), servo_rvalid, prev_sg);
            if (vec[i].vg) shadow[12'h030] = 32'hA000_0000 + 32'(i);
            if (vec[i].pe && vec[i].pw) shadow[12'h020] = 32'h77;
            if (vec[i].sg) sb.push_back(shadow[12'h030]);
            prev_sg = vec[i].sg;
            tick();
        end
        idle_inputs();
        tick();

        // VGA withdraws while the processor owns; its wait count restarts.
        do_reset();
        proc_en   = 1'b1;
        proc_wren = 1'b0;
        vga_req   = 1'b1;
        for (int i = 0; i < 63; i++) begin
            proc_wren = (i == 5);
            #1;
            if (i == 0) chk1("d_vga_gnt", vga_gnt, 1'b0);
            if (i == 0) chk1("d_wren_lo", mem_wren, 1'b0);
            if (i == 5) chk1("d_wren_hi", mem_wren, 1'b1);
            if (i == 5) chk1("d_vga_gnt_w", vga_gnt, 1'b0);
            tick();
        end
        proc_wren = 1'b0;
        vga_req   = 1'b0;
        #1;
        chk1("d_vga_gnt_drop", vga_gnt, 1'b0);
        chk1("d_starve_drop", starve, 1'b0);
        tick();
        vga_req = 1'b1;
        for (int i = 0; i <= 64; i++) begin
            #1;
            if (i == 63) chk1("d_starve_63", starve, 1'b0);
            if (i == 64) chk1("d_starve_64", starve, 1'b1);
            tick();
        end

        // Servo starves behind a continuously busy processor.
        do_reset();
        proc_en    = 1'b1;
        servo_req  = 1'b1;
        servo_addr = 12'h030;
        for (int i = 0; i <= 70; i++) begin
            #1;
            if (i == 0) chk1("b_servo_gnt", servo_gnt, 1'b0);
            if (i == 63) chk1("b_starve_63", starve, 1'b0);
            if (i == 64) chk1("b_starve_64", starve, 1'b1);
            if (i == 70) chk1("b_starve_sat", starve, 1'b1);
            tick();
        end
        idle_inputs();
        for (int i = 0; i < 3; i++) tick();
        #1;
        chk1("b_starve_sticky", starve, 1'b1);
        do_reset();
        #1;
        chk1("b_starve_reset", starve, 1'b0);
        tick();

        chk32("sb_empty", 32'(sb.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Single-port data-memory arbiter that shares the one `dmem` instance among the processor, the VGA frame writer and the servo translator. It replaces the fixed select muxes on dmem address/data/write-enable with a registered, handshaked scheduler. The processor has absolute priority because it cannot stall; the VGA and servo clients alternate round-robin behind it. The block sits between the three clients and `dmem` in `skeleton`.

## Interface
Parameters:
- `ADDR_W`, 12, dmem word-address width
- `DATA_W`, 32, dmem data width
- `STARVE_LIMIT`, 64, wait cycles after which a pending client raises `starve`

Ports:
- `clock`  in  1  system clock; `dmem` itself clocks on `~clock`
- `reset`  in  1  synchronous, active-high
- `proc_en`  in  1  processor issues a dmem access this cycle (load or store in memory stage)
- `proc_addr`  in  ADDR_W  processor address
- `proc_data`  in  DATA_W  processor store data
- `proc_wren`  in  1  processor store strobe (meaningful only with `proc_en`)
- `vga_req`  in  1  VGA write request
- `vga_addr`  in  ADDR_W  VGA write address
- `vga_wdata`  in  DATA_W  VGA write data
- `vga_gnt`  out  1  one-cycle pulse: VGA write issued this cycle
- `servo_req`  in  1  servo read request
- `servo_addr`  in  ADDR_W  servo read address
- `servo_gnt`  out  1  one-cycle pulse: servo read issued this cycle
- `servo_rvalid`  out  1  one-cycle pulse: `servo_rdata` valid
- `servo_rdata`  out  DATA_W  registered read data for servo
- `mem_addr`  out  ADDR_W  to `dmem.address`
- `mem_data`  out  DATA_W  to `dmem.data`
- `mem_wren`  out  1  to `dmem.wren`
- `mem_q`  in  DATA_W  from `dmem.q`; also routed directly to the processor outside this block
- `starve`  out  1  sticky flag: some client waited `>= STARVE_LIMIT` cycles

## Operation
- Each cycle, exactly one owner is chosen combinationally: PROC if `proc_en`; otherwise VGA or SERVO by round-robin among the asserted requests; otherwise NONE.
- `mem_addr`, `mem_data` and `mem_wren` are combinational from the owner:
  - PROC: `proc_addr`, `proc_data`, `proc_wren`.
  - VGA: `vga_addr`, `vga_wdata`, wren 1.
  - SERVO: `servo_addr`, data 0, wren 0.
  - NONE: addr 0, data 0, wren 0.
- Round-robin pointer `rr_last` (1 bit, registered) records the last non-processor winner. On a VGA/SERVO tie, the client that is not `rr_last` wins.
- `rr_last` updates only on a VGA or SERVO grant. A PROC cycle leaves it unchanged.
- Clients hold `req` and their address/data stable until `gnt`. Dropping `req` before grant is legal and simply withdraws the request.
- A client may re-assert `req` on the cycle after its `gnt`. If it is alone, back-to-back grants are allowed (one per cycle).
- Servo read pipeline: on a SERVO grant, a `pend` bit is set. On the next rising edge, `servo_rdata` <= `mem_q`, `servo_rvalid` = 1 for one cycle. `servo_rdata` holds its value until the next rvalid.
- Wait counters (one each for VGA and SERVO, width `$clog2(STARVE_LIMIT)+1`):
  - increment while `req && !gnt`;
  - clear on `gnt` or when `req` is low;
  - saturate at `STARVE_LIMIT`, with no wrap.
  - `starve` is set when either counter reaches `STARVE_LIMIT` and clears only on `reset`.
- Reset: `rr_last` = SERVO (so VGA wins the first tie), `pend` = 0, `vga_gnt` = `servo_gnt` = `servo_rvalid` = 0, `servo_rdata` = 0, counters 0, `starve` = 0. While `reset` is high, the owner is forced to NONE, so `mem_wren` = 0.

## Timing
- Grant latency: 0 cycles. `gnt` is asserted in the same cycle the request wins, and the access is presented to dmem in that cycle.
- dmem samples on the falling edge mid-cycle N, so `mem_q` is valid by the rising edge ending cycle N.
- Servo read latency: `servo_rvalid` is high in cycle N+1 for a grant in cycle N.
- Processor reads are unaffected: the processor consumes `mem_q` directly, exactly as without the arbiter.
- Reset asserted in the cycle after a servo grant: `servo_rvalid` is suppressed (stays 0) and `pend` is cleared.
- All three requesting in cycle N: PROC owns. VGA and SERVO gnt stay 0, their wait counters increment, and `rr_last` is unchanged.

## Structure
- Package `dmem_arb_pkg`:
  - owner encoding `OWN_NONE`, `OWN_PROC`, `OWN_VGA`, `OWN_SERVO` (2 bits);
  - `RR_VGA` / `RR_SERVO` constants;
  - default widths.
- Sub-module `dmem_arb_wait_ctr`: saturating wait counter with `req`, `gnt` and `limit_hit` ports, instantiated twice.
- The top-level file holds the owner select, the output mux, `rr_last`, the read pipeline and `starve`.

## Test plan
- Reset, then VGA alone requests addr 0x010, data 0xDEADBEEF → `vga_gnt` = 1 the same cycle, `mem_wren` = 1, `mem_addr` = 0x010; a later servo read of 0x010 returns `servo_rdata` = 0xDEADBEEF with `servo_rvalid` one cycle after `servo_gnt`.
- VGA and SERVO request continuously, with `proc_en` = 0 → grants alternate VGA, SERVO, VGA, … starting with VGA after reset.
- `proc_en` = 1 with store of 0x5 to 0x020 while VGA and SERVO request → `mem_addr` = 0x020, no client gnt, `rr_last` unchanged; on the first cycle `proc_en` = 0, VGA wins.
- `proc_en` held high for 64 cycles while `servo_req` = 1 → `starve` rises at wait count 64 and stays high until `reset`.
- Servo granted in cycle N, `reset` asserted in cycle N+1 → `servo_rvalid` stays 0 and `servo_rdata` = 0.
- `vga_req` dropped before grant while PROC owns → no `vga_gnt`, VGA counter returns to 0, `mem_wren` reflects only `proc_wren`.
